gfx_line_stream: RTL
====================

Name: gfx_line_stream

Overview:
Parametrised Bresenham line rasteriser with ready/valid handshakes on both sides. It accepts one line command (two endpoints) and emits one pixel coordinate per accepted output beat. It covers all octants, clips to the framebuffer and marks the final pixel. It sits between the vector/command front end and the framebuffer write arbiter, and replaces enable-gated single-step line drawing for back-pressured pixel pipelines.

Parameters:
FB_WIDTH, `VGA_MODE_H_VISIBLE, framebuffer width in pixels; X_BITS = $clog2(FB_WIDTH).
FB_HEIGHT, `VGA_MODE_V_VISIBLE, framebuffer height in pixels; Y_BITS = $clog2(FB_HEIGHT).
CLIP, 1, 1 = suppress pixels with x >= FB_WIDTH or y >= FB_HEIGHT; 0 = emit every stepped point.
SKIP_LAST, 0, 1 = do not emit the end point (for polyline chaining); 0 = emit it.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
start_valid  in  1  line command valid.
start_ready  out  1  block can accept a command (high only in IDLE).
x0  in  X_BITS  start x; sampled on start handshake.
y0  in  Y_BITS  start y.
x1  in  X_BITS  end x.
y1  in  Y_BITS  end y.
pix_valid  out  1  pix_x/pix_y hold a pixel.
pix_ready  in  1  downstream accepts the pixel.
pix_x  out  X_BITS  pixel x.
pix_y  out  Y_BITS  pixel y.
pix_last  out  1  the current beat is the final emitted pixel of the line.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when the line completes.

Behaviour:
- Reset (async): state=IDLE; pix_valid=0, pix_last=0, done=0, busy=0, pix_x=0, pix_y=0. start_ready=1 after reset deasserts. Reset mid-line drops the line with no done pulse.
- States: IDLE -> INIT_0 -> INIT_1 -> DRAW -> IDLE.
- IDLE: start_ready=1. On start_valid, register the endpoints normalised top-to-bottom: if y0 > y1, swap the endpoints; ties keep x0 as the start. Also register left_to_right = (xa < xb). Go to INIT_0.
- INIT_0: dx = |xb-xa|; dy = -(yb-ya). Both are signed, CORD_BITS+2 wide, where CORD_BITS = max(X_BITS, Y_BITS).
- INIT_1: err = dx+dy; cur = (xa,ya). Go to DRAW. When the output is accepted, the first pixel appears with pix_valid high 3 cycles after the start handshake.
- DRAW step, standard Bresenham:
  - e2 = 2*err, sign-extended with no overflow.
  - movx = (e2 >= dy); movy = (e2 <= dx); both may be set in one step.
  - On movx: x ± 1 and err += dy. On movy: y + 1 and err += dx. If both, err += dx+dy.
- Emission: the current point is "visible" unless CLIP=1 and it lies outside the framebuffer. The end point is not visible if SKIP_LAST=1.
  - Visible point: pix_valid=1. The block steps only when pix_valid && pix_ready.
  - Invisible point: stepped internally at one point per cycle with pix_valid=0.
- While pix_valid=1 && pix_ready=0, pix_x, pix_y and pix_last hold stable. No beats are dropped or duplicated.
- pix_last=1 on the beat of the last visible point. If no point at or after that one is visible, no beat carries pix_last.
- Completion: when cur == end and that point has been consumed (handshaked, or skipped as invisible), the block returns to IDLE. done pulses for 1 cycle in the first IDLE cycle. A new start may be accepted in that same cycle.
- Degenerate line (x0,y0) == (x1,y1): emits exactly 1 beat with pix_last=1 (SKIP_LAST=0), or 0 beats (SKIP_LAST=1). done pulses in both cases.
- Throughput: 1 pixel/cycle with pix_ready held high. Lines of full framebuffer span must not overflow err.
- start_valid outside IDLE is ignored; start_ready=0.

Test Plan:
1. (0,0)->(4,0), pix_ready=1 -> beats x=0..4 with y=0 on consecutive cycles, pix_last on (4,0), done 1 cycle later, first beat 3 cycles after start.
2. Steep line (0,0)->(1,3) -> exactly (0,0),(0,1),(1,2),(1,3). Reversed (3,3)->(0,0) -> (0,0),(1,1),(2,2),(3,3).
3. Back-pressure: (0,0)->(7,2) with pix_ready low for 3 cycles after beat 2 -> output held stable, the 8 beats identical to the unstalled run.
4. CLIP=1, FB_WIDTH=640: (638,5)->(642,5) -> beats only (638,5),(639,5); pix_last on (639,5); done pulses. CLIP=0 -> 5 beats.
5. Degenerate (10,10)->(10,10) -> one beat with pix_last. SKIP_LAST=1: (0,0)->(3,0) -> 3 beats, pix_last on (2,0).
6. Assert reset during the beat-2 stall of scenario 3 -> pix_valid=0 immediately, no done pulse, busy=0. A new start after release draws correctly.

Source files
------------

// File: rtl/gfx_line_stream.sv
// Bresenham line rasteriser: one two-endpoint command in, one pixel per ready/valid beat out.
// Endpoints are normalised top-to-bottom so y only ever increments while x walks either way.
`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif

module gfx_line_stream #(
    parameter int FB_WIDTH  = `VGA_MODE_H_VISIBLE,
    parameter int FB_HEIGHT = `VGA_MODE_V_VISIBLE,
    parameter bit CLIP      = 1'b1,
    parameter bit SKIP_LAST = 1'b0,
    localparam int X_BITS   = $clog2(FB_WIDTH),
    localparam int Y_BITS   = $clog2(FB_HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y1,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);
    localparam int CORD_BITS = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
    localparam int E = CORD_BITS + 2;
    localparam logic signed [E-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, INIT_0, INIT_1, DRAW} state_t;
    state_t state, state_nx;

    logic [X_BITS-1:0] xa, xb, cur_x, nxt_x, sxa, sxb;
    logic [Y_BITS-1:0] ya, yb, cur_y, nxt_y, sya, syb;
    logic ltr;
    logic signed [E-1:0] dx, dy, err, err_nx;
    logic signed [E-1:0] xa_e, xb_e, ya_e, yb_e;
    logic signed [E:0]   e2, dx_w, dy_w;
    logic mov_x, mov_y, at_end, nxt_end, vis_cur, vis_nxt, step, done_nx;

    function automatic logic visible(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y,
                                     input logic is_end);
        logic inside_fb;
        inside_fb = (int'(x) < FB_WIDTH) && (int'(y) < FB_HEIGHT);
        return (inside_fb || !CLIP) && !(SKIP_LAST && is_end);
    endfunction

    // Swap so the start point is the upper one; ties keep x0 as the start.
    always_comb begin
        if (y0 > y1) begin
            sxa = x1; sya = y1; sxb = x0; syb = y0;
        end else begin
            sxa = x0; sya = y0; sxb = x1; syb = y1;
        end
    end

    assign xa_e = E'(xa);
    assign xb_e = E'(xb);
    assign ya_e = E'(ya);
    assign yb_e = E'(yb);

    // One extra bit on e2 keeps 2*err exact for full-span lines.
    assign e2    = $signed({err, 1'b0});
    assign dx_w  = dx;
    assign dy_w  = dy;
    assign mov_x = (e2 >= dy_w);
    assign mov_y = (e2 <= dx_w);
    assign err_nx = err + (mov_x ? dy : ZERO) + (mov_y ? dx : ZERO);
    assign nxt_x = mov_x ? (ltr ? cur_x + 1'b1 : cur_x - 1'b1) : cur_x;
    assign nxt_y = mov_y ? cur_y + 1'b1 : cur_y;

    assign at_end  = (cur_x == xb) && (cur_y == yb);
    assign nxt_end = (nxt_x == xb) && (nxt_y == yb);
    assign vis_cur = visible(cur_x, cur_y, at_end);
    assign vis_nxt = visible(nxt_x, nxt_y, nxt_end);

    // Both coordinates are monotonic, so the visible points form one contiguous run:
    // the last beat is a visible point whose successor is invisible or absent.
    assign pix_valid   = (state == DRAW) && vis_cur;
    assign pix_last    = pix_valid && (at_end || !vis_nxt);
    assign pix_x       = cur_x;
    assign pix_y       = cur_y;
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nx = state;
        step     = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE:   if (start_valid) state_nx = INIT_0;
            INIT_0: state_nx = INIT_1;
            INIT_1: state_nx = DRAW;
            DRAW: begin
                if (!vis_cur || pix_ready) begin
                    if (at_end) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            xa    <= '0;
            ya    <= '0;
            xb    <= '0;
            yb    <= '0;
            ltr   <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (state == IDLE && start_valid) begin
                xa  <= sxa;
                ya  <= sya;
                xb  <= sxb;
                yb  <= syb;
                ltr <= (sxa < sxb);
            end
            if (state == INIT_0) begin
                dx <= ltr ? (xb_e - xa_e) : (xa_e - xb_e);
                dy <= ya_e - yb_e;
            end
            if (state == INIT_1) begin
                err   <= dx + dy;
                cur_x <= xa;
                cur_y <= ya;
            end
            if (step) begin
                err   <= err_nx;
                cur_x <= nxt_x;
                cur_y <= nxt_y;
            end
        end
    end
endmodule
